eth_deframer: RTL and testbench

//  Ethernet receive deframer: consumes a byte-wide AXIS stream of raw frames (preamble, SFD, dst MAC,
//  src MAC, ethertype, payload, FCS; tlast on last FCS byte) and emits the payload as AXIS.

---
 rtl/eth_deframer.sv | 242 ++++++++++++++++++++++++
 tb/tb_eth_deframer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_deframer.sv
// Ethernet receive deframer: strips preamble/SFD, header and FCS from a byte AXIS stream,
// checks the CRC-32, optionally filters on destination MAC, and reports per-frame status.
module eth_deframer #(
    parameter int unsigned PREAMBLE_MIN = 7,
    parameter bit          DST_FILTER   = 1'b0
) (
    input  logic        clk_i,
    input  logic        sresetn_i,
    input  logic [47:0] local_mac_i,
    output logic        in_axis_tready_o,
    input  logic        in_axis_tvalid_i,
    input  logic        in_axis_tlast_i,
    input  logic [7:0]  in_axis_tdata_i,
    input  logic        out_axis_tready_i,
    output logic        out_axis_tvalid_o,
    output logic        out_axis_tlast_o,
    output logic        out_axis_tuser_o,
    output logic [7:0]  out_axis_tdata_o,
    output logic [47:0] dst_mac_o,
    output logic [47:0] src_mac_o,
    output logic [15:0] ethertype_o,
    output logic        hdr_valid_o,
    output logic        stat_valid_o,
    output logic [2:0]  stat_err_o
);

    localparam logic [2:0] ErrOk   = 3'd0;
    localparam logic [2:0] ErrPre  = 3'd1;
    localparam logic [2:0] ErrRunt = 3'd2;
    localparam logic [2:0] ErrFcs  = 3'd3;
    localparam logic [2:0] ErrDst  = 3'd4;

    typedef enum logic [1:0] {StPre, StHdr, StPay, StDrop} state_e;

    state_e          state_q, state_d;
    logic            run_q;
    logic [7:0]      pre_cnt_q, pre_cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic [3:0]      hdr_cnt_q, hdr_cnt_d;
    logic [111:0]    hdr_q, hdr_d;
    logic            hdr_valid_q, hdr_valid_d;
    logic [2:0]      err_q, err_d;
    logic [3:0][7:0] dl_q, dl_d;
    logic [2:0]      dl_cnt_q, dl_cnt_d;
    logic            ov_q, ov_d;
    logic [7:0]      od_q, od_d;
    logic            ol_q, ol_d;
    logic            ou_q, ou_d;
    logic            stv_q, stv_d;
    logic [2:0]      ste_q, ste_d;

    logic        xfer;
    logic        out_fire;
    logic        last_pend;
    logic [31:0] crc_next;
    logic        bad_fcs;
    logic        pre_ok;
    logic [47:0] dst_full;
    logic        dst_ok;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign out_fire  = ov_q & out_axis_tready_i;
    assign last_pend = ov_q & ol_q;
    assign crc_next  = crc_byte(crc_q, in_axis_tdata_i);
    assign bad_fcs   = (crc_next != 32'hDEBB_20E3);
    assign pre_ok    = (32'(pre_cnt_q) >= PREAMBLE_MIN);
    assign dst_full  = {hdr_q[39:0], in_axis_tdata_i};
    assign dst_ok    = (dst_full == local_mac_i) || (dst_full == 48'hFFFF_FFFF_FFFF);

    always_comb begin
        in_axis_tready_o = 1'b0;
        unique case (state_q)
            StPre, StDrop: in_axis_tready_o = 1'b1;
            // Hold off the next header until the previous frame's last byte is delivered.
            StHdr:         in_axis_tready_o = !last_pend;
            StPay:         in_axis_tready_o = !ov_q || out_axis_tready_i;
            default:       in_axis_tready_o = 1'b0;
        endcase
        in_axis_tready_o = in_axis_tready_o & run_q;
    end

    assign xfer = in_axis_tvalid_i & in_axis_tready_o;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        crc_d       = crc_q;
        hdr_cnt_d   = hdr_cnt_q;
        hdr_d       = hdr_q;
        hdr_valid_d = hdr_valid_q;
        err_d       = err_q;
        dl_d        = dl_q;
        dl_cnt_d    = dl_cnt_q;
        ov_d        = ov_q;
        od_d        = od_q;
        ol_d        = ol_q;
        ou_d        = ou_q;
        stv_d       = 1'b0;
        ste_d       = ste_q;

        if (out_fire) begin
            ov_d = 1'b0;
            if (ol_q) hdr_valid_d = 1'b0;
        end

        unique case (state_q)
            StPre: begin
                if (xfer) begin
                    if (in_axis_tlast_i) begin
                        stv_d     = 1'b1;
                        ste_d     = ErrPre;
                        pre_cnt_d = '0;
                    end else if (in_axis_tdata_i == 8'h55) begin
                        if (!pre_ok) pre_cnt_d = pre_cnt_q + 8'd1;
                    end else if (in_axis_tdata_i == 8'hD5 && pre_ok) begin
                        state_d   = StHdr;
                        crc_d     = 32'hFFFF_FFFF;
                        hdr_cnt_d = '0;
                        pre_cnt_d = '0;
                    end else begin
                        state_d   = StDrop;
                        err_d     = ErrPre;
                        pre_cnt_d = '0;
                        if (!last_pend) hdr_valid_d = 1'b0;
                    end
                end
            end
            StHdr: begin
                if (xfer) begin
                    crc_d     = crc_next;
                    hdr_d     = {hdr_q[103:0], in_axis_tdata_i};
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (in_axis_tlast_i) begin
                        stv_d   = 1'b1;
                        ste_d   = ErrRunt;
                        state_d = StPre;
                    end else if (DST_FILTER && hdr_cnt_q == 4'd5 && !dst_ok) begin
                        state_d     = StDrop;
                        err_d       = ErrDst;
                        hdr_valid_d = 1'b0;
                    end else if (hdr_cnt_q == 4'd13) begin
                        hdr_valid_d = 1'b1;
                        state_d     = StPay;
                        dl_cnt_d    = '0;
                    end
                end
            end
            StPay: begin
                if (xfer) begin
                    crc_d = crc_next;
                    if (dl_cnt_q == 3'd4) begin
                        ov_d = 1'b1;
                        od_d = dl_q[0];
                        ol_d = in_axis_tlast_i;
                        ou_d = in_axis_tlast_i & bad_fcs;
                        dl_d = {in_axis_tdata_i, dl_q[3:1]};
                    end else begin
                        dl_d[dl_cnt_q[1:0]] = in_axis_tdata_i;
                        dl_cnt_d            = dl_cnt_q + 3'd1;
                    end
                    if (in_axis_tlast_i) begin
                        stv_d    = 1'b1;
                        state_d  = StPre;
                        dl_cnt_d = '0;
                        if (dl_cnt_q < 3'd3)  ste_d = ErrRunt;
                        else if (bad_fcs)     ste_d = ErrFcs;
                        else                  ste_d = ErrOk;
                        // With no payload emitted there is no out tlast to wait for.
                        if (dl_cnt_q != 3'd4) hdr_valid_d = 1'b0;
                    end
                end
            end
            StDrop: begin
                if (xfer && in_axis_tlast_i) begin
                    stv_d   = 1'b1;
                    ste_d   = err_q;
                    state_d = StPre;
                end
            end
            default: state_d = StPre;
        endcase
    end

    always_ff @(posedge clk_i or negedge sresetn_i) begin
        if (!sresetn_i) begin
            state_q     <= StPre;
            run_q       <= 1'b0;
            pre_cnt_q   <= '0;
            crc_q       <= '0;
            hdr_cnt_q   <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            err_q       <= '0;
            dl_q        <= '0;
            dl_cnt_q    <= '0;
            ov_q        <= 1'b0;
            od_q        <= '0;
            ol_q        <= 1'b0;
            ou_q        <= 1'b0;
            stv_q       <= 1'b0;
            ste_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            pre_cnt_q   <= pre_cnt_d;
            crc_q       <= crc_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            err_q       <= err_d;
            dl_q        <= dl_d;
            dl_cnt_q    <= dl_cnt_d;
            ov_q        <= ov_d;
            od_q        <= od_d;
            ol_q        <= ol_d;
            ou_q        <= ou_d;
            stv_q       <= stv_d;
            ste_q       <= ste_d;
        end
    end

    assign out_axis_tvalid_o = ov_q;
    assign out_axis_tdata_o  = od_q;
    assign out_axis_tlast_o  = ol_q;
    assign out_axis_tuser_o  = ou_q;
    assign dst_mac_o         = hdr_q[111:64];
    assign src_mac_o         = hdr_q[63:16];
    assign ethertype_o       = hdr_q[15:0];
    assign hdr_valid_o       = hdr_valid_q;
    assign stat_valid_o      = stv_q;
    assign stat_err_o        = ste_q;

endmodule

// File: tb/tb_eth_deframer.sv
// Directed bench for eth_deframer: instance 0 unfiltered, instance 1 with DST_FILTER and a local MAC.
`timescale 1ns/1ps
module tb_eth_deframer;

    localparam logic [47:0] Bcast = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] Src   = 48'h0200_0000_0001;
    localparam logic [47:0] Local = 48'h0200_0000_0009;

    logic        clk;
    logic        sresetn;
    logic [1:0]  in_valid, in_last, in_ready, out_ready, out_valid, out_last, out_user;
    logic [1:0]  hdr_valid, stat_valid;
    logic [7:0]  in_data  [2];
    logic [7:0]  out_data [2];
    logic [47:0] dst_mac  [2];
    logic [47:0] src_mac  [2];
    logic [15:0] ethertype[2];
    logic [2:0]  stat_err [2];

    eth_deframer #(.PREAMBLE_MIN(7), .DST_FILTER(1'b0)) u_dut0 (
        .clk_i(clk), .sresetn_i(sresetn), .local_mac_i(Local),
        .in_axis_tready_o(in_ready[0]), .in_axis_tvalid_i(in_valid[0]),
        .in_axis_tlast_i(in_last[0]), .in_axis_tdata_i(in_data[0]),
        .out_axis_tready_i(out_ready[0]), .out_axis_tvalid_o(out_valid[0]),
        .out_axis_tlast_o(out_last[0]), .out_axis_tuser_o(out_user[0]),
        .out_axis_tdata_o(out_data[0]), .dst_mac_o(dst_mac[0]), .src_mac_o(src_mac[0]),
        .ethertype_o(ethertype[0]), .hdr_valid_o(hdr_valid[0]),
        .stat_valid_o(stat_valid[0]), .stat_err_o(stat_err[0])
    );

    eth_deframer #(.PREAMBLE_MIN(7), .DST_FILTER(1'b1)) u_dut1 (
        .clk_i(clk), .sresetn_i(sresetn), .local_mac_i(Local),
        .in_axis_tready_o(in_ready[1]), .in_axis_tvalid_i(in_valid[1]),
        .in_axis_tlast_i(in_last[1]), .in_axis_tdata_i(in_data[1]),
        .out_axis_tready_i(out_ready[1]), .out_axis_tvalid_o(out_valid[1]),
        .out_axis_tlast_o(out_last[1]), .out_axis_tuser_o(out_user[1]),
        .out_axis_tdata_o(out_data[1]), .dst_mac_o(dst_mac[1]), .src_mac_o(src_mac[1]),
        .ethertype_o(ethertype[1]), .hdr_valid_o(hdr_valid[1]),
        .stat_valid_o(stat_valid[1]), .stat_err_o(stat_err[1])
    );

    int         n_total = 0;
    int         n_bad   = 0;
    int         cur     = 0;
    bit         throttle = 1'b0;
    logic [7:0] frm[$];
    logic [9:0] obq[$];
    logic [2:0] sq[$];
    bit         hv_seen;
    bit         hv_at_last;
    int         stall_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rc;
        rc = 0;
        out_ready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            out_ready[0] = throttle ? (rc % 3 == 0) : 1'b1;
            out_ready[1] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (sresetn) begin
            if (out_valid[cur] && out_ready[cur]) begin
                obq.push_back({out_user[cur], out_last[cur], out_data[cur]});
                if (out_last[cur]) hv_at_last = hdr_valid[cur];
            end
            if (stat_valid[cur]) sq.push_back(stat_err[cur]);
            if (hdr_valid[cur]) hv_seen = 1'b1;
            if (in_valid[cur] && !in_ready[cur]) stall_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [7:0] body[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (body[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ body[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    // Payload bytes are 0,1,2,... ; FCS appended from the bench's own CRC model.
    task automatic build_frame(input int npre, input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] et, input int plen);
        logic [7:0]  body[$];
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < npre; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(src[47-8*i -: 8]);
        body.push_back(et[15:8]);
        body.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) body.push_back(8'(i));
        c = ~crc_model(body);
        for (int k = 0; k < 4; k++) body.push_back(c[8*k +: 8]);
        foreach (body[k]) frm.push_back(body[k]);
    endtask

    task automatic send(input int d, input int n);
        int cyc;
        bit acc;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = frm[i];
            in_last[d]  = (i == frm.size() - 1);
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 1000) begin
                @(negedge clk);
                acc = in_ready[d];
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) begin
                check_eq("in_tready_timeout", 64'(acc), 64'd1);
                break;
            end
        end
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic clear_obs();
        obq.delete();
        sq.delete();
        hv_seen    = 1'b0;
        hv_at_last = 1'b0;
        stall_cnt  = 0;
    endtask

    task automatic drain();
        repeat (30) @(posedge clk);
    endtask

    task automatic check_frame(input string tag, input int plen, input int flip_idx,
                               input bit exp_user, input int exp_err);
        int ev;
        check_eq({tag, "_cnt"}, 64'(obq.size()), 64'(plen));
        for (int i = 0; i < obq.size() && i < plen; i++) begin
            ev = (i == flip_idx) ? (i ^ 1) : i;
            check_eq({tag, "_data"}, 64'(obq[i][7:0]), 64'(ev[7:0]));
            check_eq({tag, "_last"}, 64'(obq[i][8]), 64'(i == plen - 1));
        end
        if (plen > 0 && obq.size() == plen) begin
            check_eq({tag, "_user"}, 64'(obq[plen-1][9]), 64'(exp_user));
            check_eq({tag, "_hv_at_last"}, 64'(hv_at_last), 64'd1);
        end
        check_eq({tag, "_stat_cnt"}, 64'(sq.size()), 64'd1);
        if (sq.size() > 0) check_eq({tag, "_stat_err"}, 64'(sq[0]), 64'(exp_err));
    endtask

    initial begin
        sresetn    = 1'b0;
        in_valid   = '0;
        in_last    = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready[0]), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_eq("rst_hdr_valid", 64'(hdr_valid[0]), 64'd0);
        check_eq("rst_stat_valid", 64'(stat_valid[0]), 64'd0);
        check_eq("rst_dst_mac", 64'(dst_mac[0]), 64'd0);
        @(negedge clk);
        sresetn = 1'b1;

        // Good broadcast frame, 46-byte payload, plus exact latency of the frame end.
        cur = 0;
        clear_obs();
        build_frame(7, Bcast, Src, 16'h0800, 46);
        send(0, frm.size());
        @(negedge clk);
        check_eq("t1_stat_latency", 64'(stat_valid[0]), 64'd1);
        check_eq("t1_last_latency", 64'(out_valid[0] & out_last[0]), 64'd1);
        drain();
        check_frame("t1", 46, -1, 1'b0, 0);
        check_eq("t1_dst", 64'(dst_mac[0]), 64'(Bcast));
        check_eq("t1_src", 64'(src_mac[0]), 64'(Src));
        check_eq("t1_type", 64'(ethertype[0]), 64'h0800);

        // Corrupted payload byte 0x10 -> 0x11.
        clear_obs();
        build_frame(7, Bcast, Src, 16'h0800, 46);
        frm[7 + 1 + 14 + 16] = 8'h11;
        send(0, frm.size());
        drain();
        check_frame("t2", 46, 16, 1'b1, 3);

        // Short preamble, then a good frame.
        clear_obs();
        build_frame(2, Bcast, Src, 16'h0800, 46);
        send(0, frm.size());
        drain();
        check_frame("t3", 0, -1, 1'b0, 1);
        check_eq("t3_hv_seen", 64'(hv_seen), 64'd0);
        clear_obs();
        build_frame(7, Bcast, Src, 16'h0800, 46);
        send(0, frm.size());
        drain();
        check_frame("t3b", 46, -1, 1'b0, 0);

        // Runt inside the header, then header-only frame with a good FCS.
        clear_obs();
        build_frame(7, Bcast, Src, 16'h0800, 46);
        frm = frm[0:7 + 1 + 10 - 1];
        send(0, frm.size());
        drain();
        check_frame("t4a", 0, -1, 1'b0, 2);
        clear_obs();
        build_frame(7, Bcast, Src, 16'h0800, 0);
        send(0, frm.size());
        drain();
        check_frame("t4b", 0, -1, 1'b0, 0);

        // Output back-pressure: ready one cycle in three.
        clear_obs();
        throttle = 1'b1;
        build_frame(7, Bcast, Src, 16'h0800, 46);
        send(0, frm.size());
        drain();
        throttle = 1'b0;
        check_frame("t5", 46, -1, 1'b0, 0);
        check_eq("t5_backpressure", 64'(stall_cnt != 0), 64'd1);

        // Destination filter on instance 1.
        cur = 1;
        clear_obs();
        build_frame(7, 48'h0200_0000_0001, Src, 16'h0800, 46);
        send(1, frm.size());
        drain();
        check_frame("t6", 0, -1, 1'b0, 4);
        clear_obs();
        build_frame(7, Local, Src, 16'h0800, 46);
        send(1, frm.size());
        drain();
        check_frame("t6b", 46, -1, 1'b0, 0);
        check_eq("t6b_dst", 64'(dst_mac[1]), 64'(Local));

        // Reset mid-payload, then a good frame.
        cur = 0;
        clear_obs();
        build_frame(7, Bcast, Src, 16'h0800, 46);
        send(0, 7 + 1 + 14 + 10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t7_hv_before_rst", 64'(hdr_valid[0]), 64'd1);
        #2;
        sresetn = 1'b0;
        #1;
        check_eq("t7_rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_eq("t7_rst_out_data", 64'(out_data[0]), 64'd0);
        check_eq("t7_rst_hdr_valid", 64'(hdr_valid[0]), 64'd0);
        check_eq("t7_rst_dst", 64'(dst_mac[0]), 64'd0);
        check_eq("t7_rst_in_ready", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        sresetn = 1'b1;
        clear_obs();
        build_frame(7, Bcast, Src, 16'h0800, 46);
        send(0, frm.size());
        drain();
        check_frame("t7", 46, -1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
